// File: rtl/multi_port_fifo_if.sv
// multi_port_fifo_if: handshake bundle for the multi-lane in-order FIFO
// master: producer/consumer side (drives flush, enq_valid/enq_data, deq_ready)
// slave:  FIFO side (drives enq_ready, deq_valid/deq_data, count)
interface multi_port_fifo_if #(
  parameter int WIDTH     = 32,
  parameter int LOGDEPTH  = 3,
  parameter int ENQ_PORTS = 2,
  parameter int DEQ_PORTS = 2
);
  logic                          flush;
  logic [ENQ_PORTS-1:0]          enq_valid;
  logic [ENQ_PORTS*WIDTH-1:0]    enq_data;
  logic [ENQ_PORTS-1:0]          enq_ready;
  logic [DEQ_PORTS-1:0]          deq_valid;
  logic [DEQ_PORTS*WIDTH-1:0]    deq_data;
  logic [DEQ_PORTS-1:0]          deq_ready;
  logic [LOGDEPTH:0]             count;
  modport master (
    output flush, enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count
  );
  modport slave (
    input  flush, enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count
  );
endinterface

// File: rtl/multi_port_fifo.sv
// multi_port_fifo: in-order FIFO taking up to ENQ_PORTS and releasing up to DEQ_PORTS entries per cycle
// clk: rising-edge clock; rst: asynchronous active-low reset
// bus: flush, per-lane enqueue/dequeue valid/ready/data, occupancy count
module multi_port_fifo #(
  parameter int WIDTH     = 32,
  parameter int LOGDEPTH  = 3,
  parameter int ENQ_PORTS = 2,
  parameter int DEQ_PORTS = 2
) (
  input logic clk,
  input logic rst,
  multi_port_fifo_if.slave bus
);
  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int CW = LOGDEPTH + 1;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOGDEPTH-1:0] head, tail;
  logic [CW-1:0]       count, n_enq, n_deq;
  logic [ENQ_PORTS-1:0] enq_take;
  logic                e_go, d_go;
  // Only the unbroken prefix of valid&ready lanes from lane 0 is accepted
  always_comb begin
    n_enq = '0;
    e_go = 1'b1;
    enq_take = '0;
    bus.enq_ready = '0;
    for (int i = 0; i < ENQ_PORTS; i++) begin
      bus.enq_ready[i] = CW'(DEPTH) - count > CW'(i);
      e_go = e_go & bus.enq_valid[i] & bus.enq_ready[i];
      enq_take[i] = e_go;
      n_enq = n_enq + CW'(e_go);
    end
  end
  always_comb begin
    n_deq = '0;
    d_go = 1'b1;
    bus.deq_valid = '0;
    bus.deq_data = '0;
    for (int i = 0; i < DEQ_PORTS; i++) begin
      bus.deq_valid[i] = count > CW'(i);
      bus.deq_data[i*WIDTH +: WIDTH] = mem[head + LOGDEPTH'(i)];
      d_go = d_go & bus.deq_valid[i] & bus.deq_ready[i];
      n_deq = n_deq + CW'(d_go);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < ENQ_PORTS; i++)
      if (enq_take[i] && !bus.flush) mem[tail + LOGDEPTH'(i)] <= bus.enq_data[i*WIDTH +: WIDTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + n_deq[LOGDEPTH-1:0];
      tail <= tail + n_enq[LOGDEPTH-1:0];
      count <= count + n_enq - n_deq;
    end
  assign bus.count = count;
endmodule

// File: tb/tb_multi_port_fifo.sv
// tb_multi_port_fifo: table-driven and scoreboard-checked bench for multi_port_fifo
module tb_multi_port_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  multi_port_fifo_if #(.WIDTH(32), .LOGDEPTH(3), .ENQ_PORTS(2), .DEQ_PORTS(2)) bus ();
  multi_port_fifo #(.WIDTH(32), .LOGDEPTH(3), .ENQ_PORTS(2), .DEQ_PORTS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic [1:0]  ev;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  dr;
    logic        fl;
    int          cnt;
    logic [1:0]  er;
    logic [1:0]  dv;
  } vec_t;
  vec_t        tbl[$];
  logic [31:0] q[$];
  logic [31:0] got[$];
  int          mcnt = 0;
  int          last_ne = 0;
  int          errors = 0;
  int          checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void add(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] dr, input logic fl, input int cnt,
                              input logic [1:0] er, input logic [1:0] dv);
    vec_t v;
    v.ev = ev; v.d0 = d0; v.d1 = d1; v.dr = dr; v.fl = fl; v.cnt = cnt; v.er = er; v.dv = dv;
    tbl.push_back(v);
  endfunction
  // One clock: drive at negedge, check visible state against the model, then advance the model at posedge
  task automatic cycle(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] dr, input logic fl);
    int ne, nd;
    @(negedge clk);
    bus.enq_valid = ev;
    bus.enq_data = {d1, d0};
    bus.deq_ready = dr;
    bus.flush = fl;
    #1;
    ne = 0;
    nd = 0;
    if (ev[0] && mcnt < 8) ne = 1;
    if (ne == 1 && ev[1] && mcnt < 7) ne = 2;
    if (dr[0] && mcnt > 0) nd = 1;
    if (nd == 1 && dr[1] && mcnt > 1) nd = 2;
    chk("pre_count", bus.count, mcnt);
    chk("pre_enq_ready", bus.enq_ready, {mcnt < 7, mcnt < 8});
    chk("pre_deq_valid", bus.deq_valid, {mcnt > 1, mcnt > 0});
    for (int i = 0; i < 2; i++)
      if (mcnt > i) chk("peek_data", bus.deq_data[i*32 +: 32], q[i]);
    @(posedge clk);
    last_ne = fl ? 0 : ne;
    if (fl) begin
      q.delete();
      mcnt = 0;
    end else begin
      for (int i = 0; i < nd; i++) got.push_back(q.pop_front());
      if (ne > 0) q.push_back(d0);
      if (ne > 1) q.push_back(d1);
      mcnt = mcnt + ne - nd;
    end
  endtask
  initial begin
    int sent, recv;
    logic [1:0] ev;
    bus.enq_valid = '0;
    bus.enq_data = '0;
    bus.deq_ready = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_enq_ready", bus.enq_ready, 2'b11);
    chk("rst_deq_valid", bus.deq_valid, 2'b00);
    rst = 1'b1;
    add(2'b11, 1000, 1001, 2'b00, 0, 2, 2'b11, 2'b11);
    add(2'b11, 1002, 1003, 2'b00, 0, 4, 2'b11, 2'b11);
    add(2'b11, 1004, 1005, 2'b00, 0, 6, 2'b11, 2'b11);
    add(2'b11, 1006, 1007, 2'b00, 0, 8, 2'b00, 2'b11);
    add(2'b00, 0, 0, 2'b01, 0, 7, 2'b01, 2'b11);
    add(2'b11, 2000, 2001, 2'b00, 0, 8, 2'b00, 2'b11);
    for (int k = 0; k < 20; k++) add(2'b11, 3000, 3001, 2'b00, 0, 8, 2'b00, 2'b11);
    for (int k = 3; k >= 0; k--) add(2'b00, 0, 0, 2'b11, 0, 2 * k, 2'b11, k > 0 ? 2'b11 : 2'b00);
    for (int k = 0; k < 10; k++) add(2'b00, 0, 0, 2'b11, 0, 0, 2'b11, 2'b00);
    add(2'b10, 4000, 4001, 2'b00, 0, 0, 2'b11, 2'b00);
    add(2'b11, 4000, 4001, 2'b00, 0, 2, 2'b11, 2'b11);
    add(2'b01, 4002, 0, 2'b00, 0, 3, 2'b11, 2'b11);
    add(2'b00, 0, 0, 2'b10, 0, 3, 2'b11, 2'b11);
    add(2'b00, 0, 0, 2'b11, 0, 1, 2'b11, 2'b01);
    add(2'b00, 0, 0, 2'b11, 0, 0, 2'b11, 2'b00);
    add(2'b11, 5000, 5001, 2'b00, 0, 2, 2'b11, 2'b11);
    add(2'b11, 5002, 5003, 2'b00, 0, 4, 2'b11, 2'b11);
    for (int k = 0; k < 10; k++) add(2'b11, 5004 + 2 * k, 5005 + 2 * k, 2'b11, 0, 4, 2'b11, 2'b11);
    add(2'b11, 6000, 6001, 2'b11, 1, 0, 2'b11, 2'b00);
    foreach (tbl[n]) begin
      cycle(tbl[n].ev, tbl[n].d0, tbl[n].d1, tbl[n].dr, tbl[n].fl);
      #1;
      chk("tbl_count", bus.count, tbl[n].cnt);
      chk("tbl_enq_ready", bus.enq_ready, tbl[n].er);
      chk("tbl_deq_valid", bus.deq_valid, tbl[n].dv);
    end
    cycle(2'b11, 7000, 7001, 2'b00, 0);
    cycle(2'b11, 7002, 7003, 2'b00, 0);
    @(negedge clk);
    bus.enq_valid = '0;
    bus.deq_ready = '0;
    #1;
    chk("async_pre_count", bus.count, 4);
    #1 rst = 1'b0;
    #1;
    chk("async_deq_valid", bus.deq_valid, 2'b00);
    chk("async_count", bus.count, 0);
    chk("async_enq_ready", bus.enq_ready, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    mcnt = 0;
    got.delete();
    sent = 0;
    recv = 0;
    for (int c = 0; c < 3000 && recv < 50; c++) begin
      ev = 2'($urandom_range(0, 3));
      if (sent >= 50) ev = 2'b00;
      if (sent == 49) ev[1] = 1'b0;
      cycle(ev, 32'(1000 + sent), 32'(1001 + sent), 2'($urandom_range(0, 3)), 0);
      sent += last_ne;
      while (got.size() > 0) begin
        chk("stress_order", got.pop_front(), 32'(1000 + recv));
        recv++;
      end
      #1;
      chk("stress_max", 32'(bus.count <= 8), 1);
    end
    chk("stress_recv", recv, 50);
    chk("stress_sent", sent, 50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_port_fifo.md
Name: multi_port_fifo

Overview:
Parametrised successor to the single-lane valid/ready FIFO. It accepts up to ENQ_PORTS entries and releases up to DEQ_PORTS entries per cycle, in strict program order. It also provides a synchronous flush and an occupancy count. It sits between the fetch/decode front end and rename/dispatch as the instruction buffer, and is reused for any multi-issue in-order queue.

Parameters:
WIDTH, 32, bits per entry
LOGDEPTH, 3, log2 of entry count; DEPTH = 1<<LOGDEPTH
ENQ_PORTS, 2, enqueue lanes per cycle; 1 <= ENQ_PORTS <= DEPTH
DEQ_PORTS, 2, dequeue lanes per cycle; 1 <= DEQ_PORTS <= DEPTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
flush  input  1  discard all contents at next edge
enq_valid  input  ENQ_PORTS  per-lane write request
enq_data  input  ENQ_PORTS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
enq_ready  output  ENQ_PORTS  lane i can be accepted this cycle
deq_valid  output  DEQ_PORTS  lane i holds a valid entry
deq_data  output  DEQ_PORTS*WIDTH  lane i = entry at head+i
deq_ready  input  DEQ_PORTS  per-lane consumer accept
count  output  LOGDEPTH+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x WIDTH array with LOGDEPTH-bit head/tail pointers, modulo-DEPTH wrap. Occupancy is an explicit register, so full and empty are unambiguous. The array is not reset.
- Reset (rst low, asynchronous): head=0, tail=0, count=0. Immediately deq_valid=0 and enq_ready=all ones. Takes effect mid-operation without waiting for clk.
- enq_ready[i] = (DEPTH - count) > i. deq_valid[i] = count > i. Both are derived from registered count only. There is no combinational path from deq_ready or enq_valid to enq_ready or deq_valid.
- deq_data lane i is a combinational read of mem[head+i]. Its value is don't-care when deq_valid[i]=0.
- Accepted enqueue n_enq = length of the longest prefix from lane 0 with enq_valid[i] && enq_ready[i]. Lanes after the first gap are ignored, not written, and not counted, even if individually valid and ready.
- Lane i of the accepted prefix is written to mem[tail+i]. tail advances by n_enq.
- Accepted dequeue n_deq = longest prefix from lane 0 with deq_valid[i] && deq_ready[i]. head advances by n_deq.
- count_next = count + n_enq - n_deq. Enqueue and dequeue in the same cycle are both honoured. Capacity is judged against the pre-edge count, so a full FIFO does not accept a write in the same cycle it is popped.
- Overflow protection: lanes with enq_ready=0 are never written, whatever enq_valid is. Underflow protection: lanes with deq_valid=0 never advance head.
- flush=1 at an edge: head=tail=0 and count=0. Flush has priority over any enqueue or dequeue that cycle, and those transfers are discarded. The next cycle shows deq_valid=0 and enq_ready=all ones.
- Wrap-around: pointer arithmetic is modulo DEPTH. A multi-lane write or read straddling index DEPTH-1 -> 0 preserves lane order.
- Latency: an entry written at edge k is visible on deq_valid/deq_data after edge k. There is no same-cycle bypass.
- Ordering: output order equals input lane-then-cycle order. This holds under any mix of stalls.

Test Plan:
(All with WIDTH=32, LOGDEPTH=3, ENQ_PORTS=2, DEQ_PORTS=2.)
1. Reset/async: pulse rst low for 1 cycle -> count=0, enq_ready=2'b11, deq_valid=2'b00. Assert rst low mid-stream between edges -> deq_valid=2'b00 before the next clk edge.
2. Fill and partial-ready: enq_valid=2'b11 for 4 cycles with data 1000..1007 -> count=8, enq_ready=2'b00, deq_valid=2'b11, deq_data={1001,1000}. Drain 1 -> count=7, enq_ready=2'b01. Enq 2 lanes (2000,2001) -> only 2000 stored, count=8.
3. Overflow/underflow: with count=8, force enq_valid=2'b11 for 20 cycles -> count stays 8 and contents are unchanged. Drain all 8 -> values in order. Force deq_ready=2'b11 for 10 cycles when empty -> count stays 0.
4. Gap lanes: enq_valid=2'b10 on empty FIFO -> count stays 0. With count=3, deq_ready=2'b10 -> count stays 3, head unchanged.
5. Concurrent and wrap: preload 4 entries, then 10 cycles of 2-lane enq + 2-lane deq -> count stays 4 every cycle, pointers wrap past index 7, output sequence matches input. Flush asserted together with enq=2'b11/deq=2'b11 -> next cycle count=0, deq_valid=2'b00.
6. Stress: stream 50 items (1000..1049) with random enq_valid/deq_ready prefixes and random stalls -> all 50 received exactly once, in order, and count never exceeds 8.
